instr_sequencer: RTL and testbench

Program sequencer for `simple_cpu`: the issuing end of the 20-bit instruction interface. A 32-entry instruction store is loaded over a write port, then a start pulse runs it from address 0. Each instruction is presented on `instruction` and held for the fixed number of cycles its class needs, then replaced back-to-back by the next one until a HALT word or the end of the store. It sits between the program loader and `simple_cpu`'s `instruction` input, and replaces hand-timed stimulus.

---
 rtl/cpu_isa_pkg.sv | 33 +++
 rtl/instr_store.sv | 23 ++
 rtl/instr_sequencer.sv | 133 +++++++++++++
 tb/tb_instr_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// ISA constants shared by simple_cpu and its instruction sequencer.
// Class encodings, HALT marker bit and operand field positions.
package cpu_isa_pkg;

   localparam int INSTR_WIDTH = 20;

   typedef enum logic [1:0] {
      CLS_NOP   = 2'b00,
      CLS_ALU   = 2'b01,
      CLS_LOAD  = 2'b10,
      CLS_STORE = 2'b11
   } cls_e;

   localparam int CLS_HI   = 19;
   localparam int CLS_LO   = 18;
   localparam int HALT_BIT = 0;

   localparam int X1_HI  = 17;
   localparam int X1_LO  = 16;
   localparam int X2_HI  = 15;
   localparam int X2_LO  = 14;
   localparam int X3_HI  = 13;
   localparam int X3_LO  = 12;
   localparam int IMM_HI = 11;
   localparam int IMM_LO = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_HALT
   } seq_state_e;

endpackage

// File: rtl/instr_store.sv
// Program store: register array, one write port, one combinational
// read port. Contents survive reset.
module instr_store #(
   parameter int DW = 20,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues stored instructions to simple_cpu back-to-back, holding each
// one for the cycle count its class needs, until HALT or end of store.
module instr_sequencer #(
   parameter int INSTR_WIDTH  = 20,
   parameter int ADDR_BITS    = 5,
   parameter int ALU_CYCLES   = 3,
   parameter int LOAD_CYCLES  = 4,
   parameter int STORE_CYCLES = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   prog_we,
   input  logic [ADDR_BITS-1:0]   prog_addr,
   input  logic [INSTR_WIDTH-1:0] prog_data,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [ADDR_BITS-1:0]   pc,
   output logic                   issue,
   output logic                   busy,
   output logic                   done
);

   import cpu_isa_pkg::*;

   seq_state_e state, state_nxt;
   logic [INSTR_WIDTH-1:0] instr_nxt;
   logic [ADDR_BITS-1:0]   pc_nxt;
   logic [ADDR_BITS-1:0]   raddr;
   logic [INSTR_WIDTH-1:0] rdata;
   logic [2:0]             cnt, cnt_nxt;
   logic                   issue_nxt;

   function automatic logic [2:0] hold_of(
      input logic [INSTR_WIDTH-1:0] w
   );
      logic [2:0] h;
      unique case (cls_e'(w[CLS_HI:CLS_LO]))
         CLS_ALU:   h = 3'(ALU_CYCLES);
         CLS_LOAD:  h = 3'(LOAD_CYCLES);
         CLS_STORE: h = 3'(STORE_CYCLES);
         default:   h = 3'd1;
      endcase
      return h;
   endfunction

   function automatic logic is_halt(
      input logic [INSTR_WIDTH-1:0] w
   );
      return (w[CLS_HI:CLS_LO] == CLS_NOP) && w[HALT_BIT];
   endfunction

   // Idle/halt fetch address 0 for start; issue prefetches the next word.
   assign raddr = (state == S_ISSUE) ? pc + 1'b1 : '0;

   instr_store #(
      .DW(INSTR_WIDTH),
      .AW(ADDR_BITS)
   ) u_store (
      .clk  (clk),
      .we   (prog_we && !busy),
      .waddr(prog_addr),
      .wdata(prog_data),
      .raddr(raddr),
      .rdata(rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         instruction <= '0;
         pc          <= '0;
         cnt         <= '0;
         issue       <= 1'b0;
      end else begin
         state       <= state_nxt;
         instruction <= instr_nxt;
         pc          <= pc_nxt;
         cnt         <= cnt_nxt;
         issue       <= issue_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      instr_nxt = instruction;
      pc_nxt    = pc;
      cnt_nxt   = cnt;
      issue_nxt = 1'b0;
      unique case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_nxt = '0;
               if (is_halt(rdata)) begin
                  state_nxt = S_HALT;
                  instr_nxt = '0;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = S_ISSUE;
                  instr_nxt = rdata;
                  cnt_nxt   = hold_of(rdata);
                  issue_nxt = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (cnt == 3'd1) begin
               if (pc == '1) begin
                  state_nxt = S_HALT;
                  instr_nxt = '0;
                  cnt_nxt   = '0;
               end else if (is_halt(rdata)) begin
                  state_nxt = S_HALT;
                  instr_nxt = '0;
                  pc_nxt    = pc + 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  instr_nxt = rdata;
                  pc_nxt    = pc + 1'b1;
                  cnt_nxt   = hold_of(rdata);
                  issue_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign busy = (state == S_ISSUE);
   assign done = (state == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench: per-cycle expected outputs are queued from a program
// model when a run starts and popped one per cycle against the DUT.
module tb_instr_sequencer;

   localparam int W = 20;
   localparam int A = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic         prog_we = 1'b0;
   logic [A-1:0] prog_addr = '0;
   logic [W-1:0] prog_data = '0;
   logic [W-1:0] instruction;
   logic [A-1:0] pc;
   logic         issue, busy, done;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [W-1:0] ins;
      logic         iss;
      logic [A-1:0] pc;
      logic         busy;
      logic         done;
   } obs_t;

   obs_t         sb[$];
   logic [W-1:0] model[32];

   always #5 clk = ~clk;

   instr_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .prog_we    (prog_we),
      .prog_addr  (prog_addr),
      .prog_data  (prog_data),
      .instruction(instruction),
      .pc         (pc),
      .issue      (issue),
      .busy       (busy),
      .done       (done)
   );

   function automatic int hold_tb(input logic [W-1:0] w);
      logic [1:0] c;
      c = w[19:18];
      case (c)
         2'b01:   return 3;
         2'b10:   return 4;
         2'b11:   return 3;
         default: return 1;
      endcase
   endfunction

   function automatic logic halt_tb(input logic [W-1:0] w);
      return (w[19:18] == 2'b00) && w[0];
   endfunction

   task automatic check(input string tag, input obs_t exp);
      obs_t got;
      got = {instruction, issue, pc, busy, done};
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic wr(input int a, input logic [W-1:0] d);
      @(negedge clk);
      prog_we = 1'b1;
      prog_addr = A'(a);
      prog_data = d;
      model[a] = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic build();
      int p;
      logic [W-1:0] w;
      p = 0;
      forever begin
         w = model[p];
         if (halt_tb(w)) break;
         for (int k = 0; k < hold_tb(w); k++)
            sb.push_back({w, (k == 0), A'(p), 1'b1, 1'b0});
         if (p == 31) break;
         p++;
      end
      sb.push_back({{W{1'b0}}, 1'b0, A'(p), 1'b0, 1'b1});
   endtask

   task automatic pulse_rst(input string tag);
      @(negedge clk);
      rst = 1'b0;
      #2;
      check(tag, '0);
      rst = 1'b1;
   endtask

   task automatic run(
      input string        tag,
      input int           guard_at,
      input int           abort_at,
      input logic         w0,
      input logic [W-1:0] w0d
   );
      int cyc;
      obs_t exp;
      build();
      @(negedge clk);
      start = 1'b1;
      if (w0) begin
         prog_we = 1'b1;
         prog_addr = '0;
         prog_data = w0d;
         model[0] = w0d;
      end
      @(negedge clk);
      start = 1'b0;
      prog_we = 1'b0;
      cyc = 0;
      while (sb.size() > 0) begin
         exp = sb.pop_front();
         if (cyc == abort_at) begin
            rst = 1'b0;
            #1;
            check({tag, "_rst"}, '0);
            #1;
            rst = 1'b1;
            sb.delete();
            break;
         end
         check(tag, exp);
         if (cyc == guard_at) begin
            prog_we = 1'b1;
            prog_addr = 5'd1;
            prog_data = 20'h00001;
            start = 1'b1;
         end else begin
            prog_we = 1'b0;
            start = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      prog_we = 1'b0;
      start = 1'b0;
   endtask

   task automatic load_mixed();
      wr(0, 20'h47000);
      wr(1, 20'h53000);
      wr(2, 20'h72001);
      wr(3, 20'hD80F0);
      wr(4, 20'hB80F0);
      wr(5, 20'h00001);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      #2;
      check("reset", '0);
      rst = 1'b1;

      wr(0, 20'h47000);
      wr(1, 20'h00001);
      pulse_rst("reset_again");
      run("keep_store", -1, -1, 1'b0, '0);

      wr(1, 20'h53000);
      wr(2, 20'h00001);
      run("alu_pair", -1, -1, 1'b0, '0);

      load_mixed();
      run("mixed", -1, -1, 1'b0, '0);
      run("guard", 1, -1, 1'b0, '0);
      run("wr_start", -1, -1, 1'b1, 20'h00001);

      pulse_rst("reset_halt0");
      run("halt0", -1, -1, 1'b0, '0);

      for (int i = 0; i < 32; i++) wr(i, 20'h00000);
      run("wrap", -1, -1, 1'b0, '0);

      load_mixed();
      pulse_rst("reset_pre_abort");
      run("abort", -1, 13, 1'b0, '0);
      run("replay", -1, -1, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
